// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over LOAD/READY
// and emits it one bit per enabled clock, with FRAME/LAST strobes per word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] PDIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             DOUT,
  output logic             DOUT_VALID,
  output logic             FRAME,
  output logic             LAST
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             at_end;
  logic             accept;

  // Bit that goes on the line first for a given register image.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, sreg[WIDTH-1:1]};
  end

  assign at_end = (state == SHIFT) && (count == CNT_LAST);
  assign READY  = EN && ((state == IDLE) || at_end);
  assign accept = LOAD && READY;

  // Outputs are registered alongside the state so they always match it;
  // a reload on the final bit restarts the word with no idle gap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      count      <= '0;
      sreg       <= '0;
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
      FRAME      <= 1'b0;
      LAST       <= 1'b0;
    end else if (EN) begin
      if (accept) begin
        state      <= SHIFT;
        count      <= '0;
        sreg       <= PDIN;
        DOUT       <= head(PDIN);
        DOUT_VALID <= 1'b1;
        FRAME      <= 1'b1;
        LAST       <= 1'b0;
      end else if (state == SHIFT) begin
        if (at_end) begin
          state      <= IDLE;
          count      <= '0;
          sreg       <= '0;
          DOUT       <= 1'b0;
          DOUT_VALID <= 1'b0;
          FRAME      <= 1'b0;
          LAST       <= 1'b0;
        end else begin
          count      <= count + 1'b1;
          sreg       <= shifted;
          DOUT       <= head(shifted);
          DOUT_VALID <= 1'b1;
          FRAME      <= 1'b0;
          LAST       <= (count == CNT_PENULT);
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed test-plan steps plus randomized traffic,
// both instances (LSB-first and MSB-first) checked against a word/bit-index model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] pdin;
  logic         load;

  logic ready_l, dout_l, valid_l, frame_l, last_l;
  logic ready_m, dout_m, valid_m, frame_m, last_m;

  int unsigned tests;
  int unsigned fails;
  int unsigned vcnt;
  int unsigned fcnt;

  // Reference model: a word in flight and the index of the bit on the line.
  logic         busy;
  int unsigned  k;
  logic [W-1:0] word;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST(rst_n), .EN(en), .PDIN(pdin), .LOAD(load),
    .READY(ready_l), .DOUT(dout_l), .DOUT_VALID(valid_l), .FRAME(frame_l), .LAST(last_l)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST(rst_n), .EN(en), .PDIN(pdin), .LOAD(load),
    .READY(ready_m), .DOUT(dout_m), .DOUT_VALID(valid_m), .FRAME(frame_m), .LAST(last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic rdy;
    if (!rst_n) begin
      busy = 1'b0;
      k    = 0;
    end else if (en) begin
      rdy = !busy || (k == W - 1);
      if (load && rdy) begin
        busy = 1'b1;
        k    = 0;
        word = pdin;
      end else if (busy) begin
        if (k == W - 1) busy = 1'b0;
        else            k++;
      end
    end
  endtask

  task automatic check_all();
    logic e_l, e_m, e_fr, e_la, e_rdy;
    e_l   = busy ? word[k] : 1'b0;
    e_m   = busy ? word[W-1-k] : 1'b0;
    e_fr  = busy && (k == 0);
    e_la  = busy && (k == W - 1);
    e_rdy = en && (!busy || (k == W - 1));
    chk("dout_lsb",  32'(dout_l),  32'(e_l));
    chk("dout_msb",  32'(dout_m),  32'(e_m));
    chk("valid_lsb", 32'(valid_l), 32'(busy));
    chk("valid_msb", 32'(valid_m), 32'(busy));
    chk("frame_lsb", 32'(frame_l), 32'(e_fr));
    chk("frame_msb", 32'(frame_m), 32'(e_fr));
    chk("last_lsb",  32'(last_l),  32'(e_la));
    chk("last_msb",  32'(last_m),  32'(e_la));
    chk("ready_lsb", 32'(ready_l), 32'(e_rdy));
    chk("ready_msb", 32'(ready_m), 32'(e_rdy));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (valid_l) vcnt++;
    if (frame_l) fcnt++;
    check_all();
  endtask

  initial begin
    logic [W-1:0] seq_l;
    logic [W-1:0] seq_m;
    tests = 0;
    fails = 0;
    busy  = 1'b0;
    k     = 0;
    word  = '0;

    // Reset with LOAD held high: nothing may be accepted.
    rst_n = 1'b0;
    en    = 1'b1;
    load  = 1'b1;
    pdin  = 8'hC3;
    #2;
    check_all();
    step();
    step();
    rst_n = 1'b1;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Single word 0xB4, explicit bit order in both directions.
    seq_l = 8'b1011_0100;  // send order bit0..bit7 -> 0,0,1,0,1,1,0,1
    seq_m = 8'b0010_1101;  // send order 1,0,1,1,0,1,0,0 stored LSB-first
    pdin  = 8'hB4;
    for (int i = 0; i < W; i++) begin
      load = (i == 0);
      step();
      chk("b4_seq_lsb", 32'(dout_l), 32'(seq_l[i]));
      chk("b4_seq_msb", 32'(dout_m), 32'(seq_m[i]));
      chk("b4_ready",   32'(ready_l), 32'(i == W - 1));
    end
    load = 1'b0;
    step();
    chk("b4_idle_after", 32'(valid_l), 32'd0);

    // Back-to-back: 0xFF then 0x00 accepted exactly on the LAST cycle.
    vcnt = 0;
    fcnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      load = (i <= W);
      pdin = (i == 0) ? 8'hFF : 8'h00;
      step();
      chk("b2b_bit", 32'(dout_l), 32'(i < W));
      chk("b2b_frame", 32'(frame_l), 32'((i == 0) || (i == W)));
    end
    load = 1'b0;
    step();
    chk("b2b_valid_cycles", vcnt, 32'd16);
    chk("b2b_frames", fcnt, 32'd2);

    // Stall: EN low for 3 cycles while bit 3 of 0xA5 is on the line.
    vcnt = 0;
    pdin = 8'hA5;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_bit3", 32'(dout_l), 32'd0);
      chk("stall_ready", 32'(ready_l), 32'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("stall_valid_cycles", vcnt, 32'd11);

    // Mid-word reset after bit 4 of 0x5A, then a clean 0x3C.
    pdin = 8'h5A;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    model_edge();
    #1;
    chk("rst_dout",  32'(dout_l),  32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_frame", 32'(frame_l), 32'd0);
    chk("rst_last",  32'(last_m),  32'd0);
    check_all();
    step();
    rst_n = 1'b1;
    step();
    pdin = 8'h3C;
    for (int i = 0; i < W; i++) begin
      load = (i == 0);
      step();
      chk("post_rst_lsb", 32'(dout_l), 32'(pdin[i]));
      chk("post_rst_msb", 32'(dout_m), 32'(pdin[W-1-i]));
    end
    load = 1'b0;
    step();

    // Randomized traffic with random stalls and loads.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 2) != 0);
      pdin = W'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter for the serial shift path: accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock on a single-bit line. It drives the serial input of the downstream shift-register chain (DIN of the receiving chain). It provides framing strobes so the receiving side can realign words, and supports gapless back-to-back words.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first
- CLK  input  1  single clock; all state changes on rising edge
- RST  input  1  asynchronous, active-low reset; clears all state immediately on assertion; release is synchronous to CLK by the system
- EN  input  1  shift enable (bit-rate strobe); when 0 all state holds
- PDIN  input  WIDTH  parallel word to transmit
- LOAD  input  1  PDIN valid
- READY  output  1  block can accept a word this cycle
- DOUT  output  1  serial data bit
- DOUT_VALID  output  1  DOUT carries a word bit
- FRAME  output  1  high with the first bit of each word
- LAST  output  1  high with the final bit of each word

## Operation
- Internal state: WIDTH-bit shift register, bit counter of width $clog2(WIDTH), two-state FSM IDLE/SHIFT.
- READY = EN and (state == IDLE or (state == SHIFT and count == WIDTH-1)); combinational from registered state plus EN.
- Accept: LOAD and READY at a rising edge. Word is captured, FSM goes to (or stays in) SHIFT, count = 0.
- IDLE -> SHIFT on accept. LOAD while READY = 0 is ignored; there is no buffering and PDIN is sampled only on accept.
- SHIFT: each edge with EN = 1 advances one bit. Count increments, and the register shifts right (MSB_FIRST=0) or left (MSB_FIRST=1).
- At count == WIDTH-1 with EN = 1:
  - If accepting, reload and stay in SHIFT with count = 0, giving zero gap between words.
  - Otherwise go to IDLE.
- DOUT = register bit 0 (MSB_FIRST=0) or bit WIDTH-1 (MSB_FIRST=1) while in SHIFT; 0 in IDLE.
- DOUT_VALID = (state == SHIFT).
- FRAME = SHIFT and count == 0.
- LAST = SHIFT and count == WIDTH-1.
- EN = 0: counter, register, FSM and all outputs hold their values. READY is 0.
- Reset values: state IDLE, count 0, register 0, DOUT 0, DOUT_VALID 0, FRAME 0, LAST 0. READY follows EN, so it is 1 if EN = 1.
- Reset asserted mid-word: the word is discarded and no further bits are emitted. After release the block is IDLE.

## Timing
- Latency: first bit appears on DOUT in the cycle after the accepting edge. DOUT_VALID and FRAME rise at that same edge.
- A word occupies exactly WIDTH enabled cycles on DOUT. Bit k (in send order) is present during the k-th enabled cycle after accept.
- Back-to-back: an accept on the LAST cycle makes the next cycle FRAME of the new word. DOUT_VALID stays continuously high.
- Throughput: one word per WIDTH enabled cycles maximum.
- Stalls (EN low) stretch the current bit. FRAME and LAST stay high for the whole stretched bit.
- All outputs except READY are registered or derived only from registered state.

## Test plan
- Reset and idle: drive RST low with LOAD=1, then release with EN=1 and LOAD=0.
  - Required: DOUT=0, DOUT_VALID=0, FRAME=0, LAST=0, READY=1 throughout.
- Single word, WIDTH=8, MSB_FIRST=0: load 0xB4.
  - Required: DOUT sequence 0,0,1,0,1,1,0,1 over 8 cycles.
  - FRAME high on cycle 1 only, LAST on cycle 8 only, READY high only on cycle 8.
  - IDLE on cycle 9.
- MSB_FIRST=1: load 0xB4.
  - Required: DOUT sequence 1,0,1,1,0,1,0,0.
- Back-to-back: load 0xFF, then hold LOAD=1 with PDIN=0x00.
  - Required: 8 ones then 8 zeros with no gap in DOUT_VALID.
  - FRAME pulses at cycles 1 and 9.
  - Second accept occurs exactly on the LAST cycle; LOAD in cycles 2..7 is ignored.
- EN stalls: load 0xA5 and drop EN for 3 cycles after bit 3.
  - Required: bit 3 held for 4 cycles, remaining bits unchanged, total 11 cycles of DOUT_VALID.
  - READY=0 while EN=0.
- Mid-word reset: assert RST after bit 4 of 0x5A.
  - Required: outputs go to reset values immediately.
  - After release, a new load of 0x3C is transmitted correctly from FRAME.
